// File: rtl/ntt_addr_gen_pkg.sv
// Shared sizes, FSM encoding and index helpers for the NTT address sequencer.
// N = 2^LOGN coefficients spread over four banks of 2^ADDR_W words.
package ntt_addr_gen_pkg;
    localparam int LOGN      = 11;
    localparam int ADDR_W    = LOGN - 2;
    localparam int PIPE_LAT  = 8;
    localparam int NUM_LANES = 4;
    localparam int STAGE_W   = 4;
    localparam int TW_W      = LOGN - 1;
    localparam int GCNT_W    = $clog2(PIPE_LAT);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

    typedef struct packed {
        logic [1:0]        idx;
        logic [ADDR_W-1:0] addr;
    } bank_loc_t;

    // Second butterfly bit: the next stage up, except on the last stage.
    function automatic logic [STAGE_W-1:0] partner_bit(input logic [STAGE_W-1:0] s);
        return (s < STAGE_W'(LOGN - 1)) ? s + STAGE_W'(1) : s - STAGE_W'(1);
    endfunction

    function automatic logic [LOGN-1:0] insert_two_zeros(input logic [ADDR_W-1:0]  c,
                                                         input logic [STAGE_W-1:0] s,
                                                         input logic [STAGE_W-1:0] t);
        logic [LOGN-1:0]   r;
        logic [ADDR_W-1:0] rem;
        r   = '0;
        rem = c;
        for (int j = 0; j < LOGN; j++) begin
            if (j != int'(s) && j != int'(t)) begin
                r[j] = rem[0];
                rem  = rem >> 1;
            end
        end
        return r;
    endfunction

    // Even-position parity picks bank bit 0, odd-position parity bank bit 1.
    function automatic logic [1:0] bank_of(input logic [LOGN-1:0] j);
        logic [1:0] b;
        b = '0;
        for (int k = 0; k < LOGN; k++) begin
            if (k % 2 == 0) b[0] = b[0] ^ j[k];
            else            b[1] = b[1] ^ j[k];
        end
        return b;
    endfunction
endpackage

// File: rtl/ntt_addr_gen_if.sv
// Control and address bus between the NTT sequencer and the banked memory wrapper.
interface ntt_addr_gen_if import ntt_addr_gen_pkg::*; ();
    logic               start;
    logic               en;
    logic               busy;
    logic               done;
    logic [STAGE_W-1:0] stage;
    logic               ren;
    logic               wen;
    logic [1:0]         newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx;
    logic [ADDR_W-1:0]  newadd0, newadd1, newadd2, newadd3;
    logic [TW_W-1:0]    tw0_exp, tw1_exp;

    modport master (
        input  start, en,
        output busy, done, stage, ren, wen,
        output newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx,
        output newadd0, newadd1, newadd2, newadd3,
        output tw0_exp, tw1_exp
    );

    modport slave (
        output start, en,
        input  busy, done, stage, ren, wen,
        input  newadd0_idx, newadd1_idx, newadd2_idx, newadd3_idx,
        input  newadd0, newadd1, newadd2, newadd3,
        input  tw0_exp, tw1_exp
    );
endinterface

// File: rtl/ntt_bank_map.sv
// Coefficient index -> {bank, in-bank address}; bijective over 0..N-1.
module ntt_bank_map
    import ntt_addr_gen_pkg::*;
(
    input  logic [LOGN-1:0] index,
    output bank_loc_t       loc
);
    assign loc.idx  = bank_of(index);
    assign loc.addr = index[LOGN-1:2];
endmodule

// File: rtl/ntt_addr_gen.sv
// Per-cycle four-lane address sequencer for a forward NTT with drain gaps between stages.
// The next group is formed combinationally so it is registered in the same edge that issues it.
module ntt_addr_gen
    import ntt_addr_gen_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    ntt_addr_gen_if.master bus
);
    state_t                           state;
    logic [STAGE_W-1:0]               stage_q, grp_stage, grp_t;
    logic [ADDR_W-1:0]                cnt, grp_cnt;
    logic [GCNT_W-1:0]                gcnt;
    logic                             busy_q, done_q, ren_q;
    logic [LOGN-1:0]                  base, s_bit, t_bit, tw_mask;
    logic [NUM_LANES-1:0][LOGN-1:0]   lane_ix;
    bank_loc_t [NUM_LANES-1:0]        lane_loc, loc_q;
    logic [TW_W-1:0]                  tw0_nxt, tw1_nxt, tw0_q, tw1_q;

    // Stage/count of the group that would be issued at the coming edge.
    always_comb begin
        grp_stage = stage_q;
        grp_cnt   = cnt + ADDR_W'(1);
        case (state)
            ST_IDLE: begin
                grp_stage = '0;
                grp_cnt   = '0;
            end
            ST_GAP: begin
                grp_stage = (stage_q == STAGE_W'(LOGN - 1)) ? '0 : stage_q + STAGE_W'(1);
                grp_cnt   = '0;
            end
            default: ;
        endcase
        grp_t   = partner_bit(grp_stage);
        base    = insert_two_zeros(grp_cnt, grp_stage, grp_t);
        s_bit   = LOGN'(1) << grp_stage;
        t_bit   = LOGN'(1) << grp_t;
        tw_mask = s_bit - LOGN'(1);
        lane_ix[0] = base;
        lane_ix[1] = base | s_bit;
        lane_ix[2] = base | t_bit;
        lane_ix[3] = base | t_bit | s_bit;
        // Bit t of base is zero, so base + 2^t is a plain OR.
        tw0_nxt = TW_W'((base & tw_mask) << (TW_W - int'(grp_stage)));
        tw1_nxt = TW_W'(((base | t_bit) & tw_mask) << (TW_W - int'(grp_stage)));
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ntt_bank_map u_map (.index(lane_ix[l]), .loc(lane_loc[l]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            stage_q <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            loc_q   <= '0;
            tw0_q   <= '0;
            tw1_q   <= '0;
        end else begin
            done_q <= 1'b0;
            ren_q  <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    state   <= ST_RUN;
                    stage_q <= '0;
                    cnt     <= '0;
                    busy_q  <= 1'b1;
                    ren_q   <= 1'b1;
                    loc_q   <= lane_loc;
                    tw0_q   <= tw0_nxt;
                    tw1_q   <= tw1_nxt;
                end
                ST_RUN: if (bus.en) begin
                    if (cnt == '1) begin
                        state <= ST_GAP;
                        gcnt  <= '0;
                    end else begin
                        cnt   <= grp_cnt;
                        ren_q <= 1'b1;
                        loc_q <= lane_loc;
                        tw0_q <= tw0_nxt;
                        tw1_q <= tw1_nxt;
                    end
                end
                ST_GAP: begin
                    if (gcnt == GCNT_W'(PIPE_LAT - 1)) begin
                        if (stage_q == STAGE_W'(LOGN - 1)) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            stage_q <= grp_stage;
                            cnt     <= '0;
                            ren_q   <= 1'b1;
                            loc_q   <= lane_loc;
                            tw0_q   <= tw0_nxt;
                            tw1_q   <= tw1_nxt;
                        end
                    end else begin
                        gcnt <= gcnt + GCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stage       = stage_q;
    assign bus.ren         = ren_q;
    assign bus.wen         = ren_q;
    assign bus.newadd0_idx = loc_q[0].idx;
    assign bus.newadd1_idx = loc_q[1].idx;
    assign bus.newadd2_idx = loc_q[2].idx;
    assign bus.newadd3_idx = loc_q[3].idx;
    assign bus.newadd0     = loc_q[0].addr;
    assign bus.newadd1     = loc_q[1].addr;
    assign bus.newadd2     = loc_q[2].addr;
    assign bus.newadd3     = loc_q[3].addr;
    assign bus.tw0_exp     = tw0_q;
    assign bus.tw1_exp     = tw1_q;
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed checks of the NTT address sequencer: reset, group contents, timing, stall and restart.
module tb_ntt_addr_gen;
    import ntt_addr_gen_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   seen [LOGN][2048];

    ntt_addr_gen_if bus ();
    ntt_addr_gen dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    logic [43:0] lanes_obs;
    logic [24:0] misc_obs;
    assign lanes_obs = {bus.newadd0_idx, bus.newadd0, bus.newadd1_idx, bus.newadd1,
                        bus.newadd2_idx, bus.newadd2, bus.newadd3_idx, bus.newadd3};
    assign misc_obs  = {bus.stage, bus.ren, bus.tw0_exp, bus.tw1_exp};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [43:0] lv(input int i0, a0, i1, a1, i2, a2, i3, a3);
        return {i0[1:0], a0[8:0], i1[1:0], a1[8:0], i2[1:0], a2[8:0], i3[1:0], a3[8:0]};
    endfunction

    function automatic logic [24:0] mv(input int s, input int r, input int t0, input int t1);
        return {s[3:0], r[0], t0[9:0], t1[9:0]};
    endfunction

    // Inverse of the bank map: low two index bits recovered from the bank parities.
    function automatic int unmap(input logic [1:0] b, input logic [8:0] a);
        logic [10:0] j;
        j    = {a, 2'b00};
        j[0] = b[0] ^ a[0] ^ a[2] ^ a[4] ^ a[6] ^ a[8];
        j[1] = b[1] ^ a[1] ^ a[3] ^ a[5] ^ a[7];
        return int'(j);
    endfunction

    function automatic int cyc(input bit stall, input int c);
        return (stall && c > 100) ? c + 5 : c;
    endfunction

    task automatic run_full(input bit stall);
        int done_at = -1, idle_run = 0, idle_total = 0, ren_total = 0;
        int bad_wen = 0, bad_dist = 0, dup = 0, bad_gap = 0, bad_busy = 0, bad_stage = 0;
        int ren_per_stage [16];
        logic [1:0] b [4];
        logic [8:0] a [4];
        logic [3:0] m;
        for (int s = 0; s < 16; s++) ren_per_stage[s] = 0;
        for (int s = 0; s < LOGN; s++) for (int j = 0; j < 2048; j++) seen[s][j] = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int n = 1; n <= 6000; n++) begin
            if (!bus.busy) bad_busy++;
            if (bus.ren) begin
                ren_per_stage[bus.stage]++;
                ren_total++;
                if (bus.wen !== 1'b1) bad_wen++;
                b = '{bus.newadd0_idx, bus.newadd1_idx, bus.newadd2_idx, bus.newadd3_idx};
                a = '{bus.newadd0, bus.newadd1, bus.newadd2, bus.newadd3};
                m = '0;
                for (int l = 0; l < 4; l++) begin
                    m[b[l]] = 1'b1;
                    if (seen[bus.stage][unmap(b[l], a[l])]) dup++;
                    seen[bus.stage][unmap(b[l], a[l])] = 1'b1;
                end
                if (m != 4'hf) bad_dist++;
                if (idle_run != 0 && idle_run != PIPE_LAT) bad_gap++;
                idle_run = 0;
            end else if (!bus.done && !(stall && n > 100 && n <= 105)) begin
                idle_run++;
                idle_total++;
                if (bus.wen !== 1'b0) bad_wen++;
            end
            if (n == cyc(stall, 1)) begin
                check("s0c0_lanes", lanes_obs, lv(0, 0, 1, 0, 2, 0, 3, 0));
                check("s0c0_misc", misc_obs, mv(0, 1, 0, 0));
            end
            if (n == cyc(stall, 1562)) begin
                check("s3c1_lanes", lanes_obs, lv(1, 0, 3, 2, 0, 4, 2, 6));
                check("s3c1_misc", misc_obs, mv(3, 1, 128, 128));
            end
            if (n == cyc(stall, 5201)) begin
                check("s10c0_lanes", lanes_obs, lv(0, 0, 1, 256, 2, 128, 3, 384));
                check("s10c0_misc", misc_obs, mv(10, 1, 0, 512));
            end
            if (stall) begin
                if (n == 100) begin
                    check("pre_stall", lanes_obs, lv(0, 99, 1, 99, 2, 99, 3, 99));
                    bus.en    = 1'b0;
                    bus.start = 1'b1;
                end
                if (n == 101) bus.start = 1'b0;
                if (n > 100 && n <= 105)
                    check("stall_hold", {bus.ren, bus.wen, lanes_obs}, {2'b00, lv(0, 99, 1, 99, 2, 99, 3, 99)});
                if (n == 105) bus.en = 1'b1;
                if (n == 106) begin
                    check("resume_lanes", lanes_obs, lv(2, 100, 3, 100, 0, 100, 1, 100));
                    check("resume_misc", {bus.stage, bus.ren}, {4'd0, 1'b1});
                end
            end
            if (bus.done) begin
                done_at = n;
                break;
            end
            tick;
        end
        for (int s = 0; s < LOGN; s++) if (ren_per_stage[s] != 512) bad_stage++;
        check("done_latency", done_at, stall ? 5726 : 5721);
        check("ren_per_stage", bad_stage, 0);
        check("ren_total", ren_total, 512 * LOGN);
        check("idle_total", idle_total, PIPE_LAT * LOGN);
        check("last_gap", idle_run, PIPE_LAT);
        check("gap_len", bad_gap, 0);
        check("wen_eq_ren", bad_wen, 0);
        check("bank_distinct", bad_dist, 0);
        check("index_dup", dup, 0);
        check("busy_span", bad_busy, 0);
        tick;
        check("after_done", {bus.busy, bus.done, bus.ren}, 3'b000);
    endtask

    initial begin
        int saw_done = 0;
        bus.start = 1'b0;
        bus.en    = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) tick;
        check("rst_ctrl", {bus.busy, bus.done, bus.ren, bus.wen, bus.stage}, '0);
        check("rst_lanes", lanes_obs, '0);
        check("rst_tw", {bus.tw0_exp, bus.tw1_exp}, '0);
        rstn = 1'b1;
        tick;

        run_full(1'b0);
        repeat (3) tick;
        run_full(1'b1);
        repeat (3) tick;

        // Abort a run during stage 3, then restart from scratch.
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (1599) tick;
        check("pre_rst_stage", {bus.stage, bus.ren, bus.busy}, {4'd3, 1'b1, 1'b1});
        rstn = 1'b0;
        #1;
        check("midrst_ctrl", {bus.busy, bus.done, bus.ren, bus.wen, bus.stage}, '0);
        check("midrst_lanes", lanes_obs, '0);
        check("midrst_tw", {bus.tw0_exp, bus.tw1_exp}, '0);
        repeat (3) begin
            tick;
            if (bus.done) saw_done++;
        end
        rstn = 1'b1;
        repeat (3) begin
            tick;
            if (bus.done || bus.busy) saw_done++;
        end
        check("midrst_no_done", saw_done, 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        check("restart_lanes", lanes_obs, lv(0, 0, 1, 0, 2, 0, 3, 0));
        check("restart_misc", {misc_obs, bus.busy}, {mv(0, 1, 0, 0), 1'b1});
        tick;
        check("restart_c1", lanes_obs, lv(1, 1, 0, 1, 3, 1, 2, 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
